// File: rtl/sync_fifo_if.sv
// Handshake bundle between a sync_fifo and its user.
// master: drives wr_en/wr_data/rd_en; slave: drives data, flags, count, error pulses.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Ports: clk, rst (sync, active-high), bus (sync_fifo_if.slave).
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    ADDR_WIDTH'(0) + (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF =
    (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE =
    (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full;
  logic empty;
  logic wr_ok;
  logic rd_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Acceptance uses pre-edge occupancy, so a full FIFO
  // rejects a write even when a read pops in the same cycle.
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.wr_en && full;
      underflow_q <= bus.rd_en && empty;
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_ok && !rd_ok: count_q <= count_q + 1'b1;
        rd_ok && !wr_ok: count_q <= count_q - 1'b1;
        default:         count_q <= count_q;
      endcase
    end
  end

  // Storage is never reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      mem[wr_ptr] <= bus.wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem[rd_ptr];
  assign bus.rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok)
        rd_data_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized bench for sync_fifo against a queue model,
// plus directed fill/drain, error-pulse, wrap and reset cases.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue plus the last popped word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data = '0;
  bit            m_rd_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  always @(posedge clk) begin
    bit was_full, was_empty, wok, rok;
    if (rst) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wok = bus.wr_en && !was_full;
      rok = bus.rd_en && !was_empty;
      m_ovf = bus.wr_en && was_full;
      m_unf = bus.rd_en && was_empty;
      m_rd_valid = rok;
      if (rok) m_rd_data = q.pop_front();
      if (wok) q.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(bus.count), q.size());
      chk("full", int'(bus.full), int'(q.size() == DEPTH));
      chk("empty", int'(bus.empty), int'(q.size() == 0));
      chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= AE));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("underflow", int'(bus.underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_valid", int'(bus.rd_valid), int'(q.size() != 0));
      if (q.size() != 0)
        chk("rd_data", int'(bus.rd_data), int'(q[0]));
`else
      chk("rd_valid", int'(bus.rd_valid), int'(m_rd_valid));
      chk("rd_data", int'(bus.rd_data), int'(m_rd_data));
`endif
    end
  end

  task automatic step(input logic we, input logic [DW-1:0] wd,
                      input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic pop_word(output logic [DW-1:0] w);
`ifdef SYNC_FIFO_FWFT_EN
    w = bus.rd_data;
    step(1'b0, '0, 1'b1);
`else
    step(1'b0, '0, 1'b1);
    w = bus.rd_data;
`endif
  endtask

  initial begin
    logic [DW-1:0] w;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    #1 chk_en = 1'b1;

    chk("lit_rst_count", int'(bus.count), 0);
    chk("lit_rst_empty", int'(bus.empty), 1);
    chk("lit_rst_ae", int'(bus.almost_empty), 1);
    chk("lit_rst_full", int'(bus.full), 0);
    chk("lit_rst_af", int'(bus.almost_full), 0);
    chk("lit_rst_valid", int'(bus.rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("lit_rst_data", int'(bus.rd_data), 0);
`endif

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 4)  chk("lit_ae_at4", int'(bus.almost_empty), 1);
      if (i == 5)  chk("lit_ae_at5", int'(bus.almost_empty), 0);
      if (i == 11) chk("lit_af_at11", int'(bus.almost_full), 0);
      if (i == 12) chk("lit_af_at12", int'(bus.almost_full), 1);
    end
    chk("lit_fill_count", int'(bus.count), 16);
    chk("lit_fill_full", int'(bus.full), 1);

    step(1'b1, 8'hAA, 1'b0);
    chk("lit_ovf_pulse", int'(bus.overflow), 1);
    chk("lit_ovf_count", int'(bus.count), 16);
    step(1'b0, '0, 1'b0);
    chk("lit_ovf_clear", int'(bus.overflow), 0);

    for (int i = 1; i <= 16; i++) begin
      pop_word(w);
      chk("lit_drain_data", int'(w), i);
    end
    chk("lit_drain_empty", int'(bus.empty), 1);

    step(1'b0, '0, 1'b1);
    chk("lit_unf_pulse", int'(bus.underflow), 1);
    chk("lit_unf_valid", int'(bus.rd_valid), 0);
    chk("lit_unf_count", int'(bus.count), 0);
    step(1'b1, 8'h55, 1'b1);
    chk("lit_wr_on_empty", int'(bus.count), 1);
    pop_word(w);
    chk("lit_pop55", int'(w), 'h55);

    for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("lit_stream", int'(bus.rd_data), i);
      step(1'b1, DW'(8 + i), 1'b1);
`else
      step(1'b1, DW'(8 + i), 1'b1);
      chk("lit_stream", int'(bus.rd_data), i);
`endif
    end
    chk("lit_stream_count", int'(bus.count), 8);

    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hE1, 1'b0);
    chk("lit_pre_rst_count", int'(bus.count), 10);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    chk("lit_mid_rst_count", int'(bus.count), 0);
    chk("lit_mid_rst_empty", int'(bus.empty), 1);
    chk("lit_mid_rst_valid", int'(bus.rd_valid), 0);

    step(1'b1, 8'h3C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("lit_3c_valid", int'(bus.rd_valid), 1);
    chk("lit_3c_data", int'(bus.rd_data), 'h3C);
    step(1'b0, '0, 1'b1);
    chk("lit_3c_gone", int'(bus.rd_valid), 0);
`else
    chk("lit_3c_novalid", int'(bus.rd_valid), 0);
    step(1'b0, '0, 1'b1);
    chk("lit_3c_valid", int'(bus.rd_valid), 1);
    chk("lit_3c_data", int'(bus.rd_data), 'h3C);
    step(1'b0, '0, 1'b0);
    chk("lit_3c_onecyc", int'(bus.rd_valid), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 70 : 30;
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 99) < wp, DW'($urandom),
           $urandom_range(0, 99) < (100 - wp));
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; legal values are powers of 2, >= 4.
REQ-003 Parameter AF_LEVEL, default 12, SHALL set the almost_full threshold; legal range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 4, SHALL set the almost_empty threshold; legal range 1..DEPTH-1.
REQ-005 Derived ADDR_WIDTH = log2(DEPTH) SHALL size pointers; it SHALL NOT be a port-level override.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  DATA_WIDTH  write word.
REQ-011 rd_en  input  1  read request (pop acknowledge in FWFT mode).
REQ-012 rd_data  output  DATA_WIDTH  read word.
REQ-013 rd_valid  output  1  rd_data holds a valid popped/head word.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-015 almost_full / almost_empty  output  1 each  count >= AF_LEVEL / count <= AE_LEVEL.
REQ-016 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow / underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Write SHALL be accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Read SHALL be accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-020 Full/empty SHALL be evaluated on pre-edge state: write when full is rejected even with a same-cycle read; read when empty is rejected even with a same-cycle write.
REQ-021 count SHALL update on the same edge: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH or goes below 0.
REQ-022 full, empty, almost_full, almost_empty SHALL be combinational decodes of the count register (zero extra latency vs count).
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL not disturb count or flags.
REQ-024 overflow SHALL pulse high for exactly one cycle following any edge with wr_en && full; underflow likewise for rd_en && empty.
REQ-025 Rejected requests SHALL not modify memory, pointers, count or rd_data.
REQ-026 Standard mode: accepted read loads mem[rd_ptr] into registered rd_data; rd_valid high for the following cycle only; rd_data holds its value otherwise.

Reset
REQ-027 While rst is high at a clock edge, wr_ptr, rd_ptr, count SHALL clear to 0; wr_en/rd_en SHALL be ignored.
REQ-028 Reset values: rd_data 0, rd_valid 0, overflow 0, underflow 0, empty 1, almost_empty 1, full 0, almost_full 0.
REQ-029 Memory array SHALL NOT be reset; reset mid-operation discards all stored words logically.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode when defined.
REQ-031 With SYNC_FIFO_FWFT_EN: rd_data = mem[rd_ptr] combinationally, rd_valid = !empty, rd_en pops the displayed word; head word visible the cycle after its write is accepted into an empty FIFO.
REQ-032 Without SYNC_FIFO_FWFT_EN: standard mode per REQ-026; no other behaviour differs between modes.

Verification (DEPTH=16, DATA_WIDTH=8, AF=12, AE=4)
REQ-033 Reset then write 0x01..0x10 -> count 16, full=1, almost_full asserted when count reaches 12, almost_empty deasserted when count reaches 5.
REQ-034 Full FIFO, wr_en=1 with 0xAA -> overflow pulse 1 cycle, count stays 16, later reads return 0x01..0x10 only, no 0xAA.
REQ-035 Empty FIFO, rd_en=1 -> underflow pulse 1 cycle, rd_valid 0, count 0; simultaneous write 0x55 -> accepted, count 1.
REQ-036 Count 8, wr_en and rd_en together for 40 cycles, incrementing data -> count stays 8, pointers wrap, data returned in order.
REQ-037 Count 10, assert rst 1 cycle with wr_en=1 -> count 0, empty=1, rd_valid 0, write ignored.
REQ-038 Both modes: write 0x3C into empty FIFO -> FWFT: rd_data=0x3C, rd_valid=1 next cycle without rd_en; standard: 0x3C with rd_valid 1 cycle after rd_en accepted.
